// File: rtl/tts_game_pkg.sv
// Shared game definitions: behaviour/direction encodings, tile field slices
// and the 4-bit Manhattan distance helper. Locations are {y[3:0],x[3:0]}.
package tts_game_pkg;

   typedef enum logic [1:0] {
      ST_CONTEST = 2'b00,
      ST_RETREAT = 2'b01,
      ST_SCATTER = 2'b10,
      ST_DEAD    = 2'b11
   } behaviour_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_t;

   localparam int LOC_X_LSB   = 0;
   localparam int LOC_Y_LSB   = 4;
   localparam int LOC_FIELD_W = 4;

   function automatic logic [3:0] loc_x(input logic [7:0] loc);
      return loc[LOC_X_LSB +: LOC_FIELD_W];
   endfunction

   function automatic logic [3:0] loc_y(input logic [7:0] loc);
      return loc[LOC_Y_LSB +: LOC_FIELD_W];
   endfunction

   // |dx| + |dy| with 4-bit magnitudes; the 5-bit result cannot overflow.
   function automatic logic [4:0] manhattan4(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] dx;
      logic [3:0] dy;
      dx = (loc_x(a) > loc_x(b)) ? loc_x(a) - loc_x(b) : loc_x(b) - loc_x(a);
      dy = (loc_y(a) > loc_y(b)) ? loc_y(a) - loc_y(b) : loc_y(b) - loc_y(a);
      return {1'b0, dx} + {1'b0, dy};
   endfunction

endpackage

// File: rtl/dragon_target_select.sv
// Combinational target picker for the dragon: chase the nearer of player and
// sheep, flee to the far corner, or wander to the scatter LFSR value.
module dragon_target_select
   import tts_game_pkg::*;
(
   input  logic [1:0] state,
   input  logic [7:0] head,
   input  logic [7:0] player,
   input  logic [7:0] sheep,
   input  logic [7:0] lfsr,
   output logic [7:0] target
);

   logic [4:0] dist_player;
   logic [4:0] dist_sheep;

   assign dist_player = manhattan4(head, player);
   assign dist_sheep  = manhattan4(head, sheep);

   always_comb begin
      target = lfsr;
      case (behaviour_t'(state))
         // A tie goes to the sheep, so only a strictly closer player wins.
         ST_CONTEST: target = (dist_player < dist_sheep) ? player : sheep;
         ST_RETREAT: target = {(loc_y(player) < 4'd8) ? 4'hF : 4'h0,
                               (loc_x(player) < 4'd8) ? 4'hF : 4'h0};
         default:    target = lfsr;
      endcase
   end

endmodule

// File: rtl/dragon_behaviour_ctrl.sv
// Dragon behaviour sequencer: CONTEST/RETREAT/SCATTER/DEAD FSM, body length,
// scatter LFSR and the move_req handshake. DRAGON_SPEEDUP_EN shortens the move period with length.
module dragon_behaviour_ctrl
   import tts_game_pkg::*;
#(
   parameter int         MOVE_PERIOD    = 8,
   parameter int         SCATTER_FRAMES = 120,
   parameter int         RETREAT_FRAMES = 90,
   parameter int         INIT_LENGTH    = 3,
   parameter int         MAX_LENGTH     = 8,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
)
(
   input  logic       frame_clk,
   input  logic       rst,
   input  logic [7:0] player_location,
   input  logic [7:0] sheep_location,
   input  logic [7:0] dragon_head_location,
   input  logic       sheep_eaten,
   input  logic       player_hit,
   input  logic       dragon_hit,
   input  logic       move_ack,
   output logic       move_req,
   output logic [7:0] target_tile,
   output logic [1:0] behaviour_state,
   output logic [3:0] body_length,
   output logic       dragon_win,
   output logic       game_over
);

   localparam logic [5:0] PERIOD_W     = 6'(MOVE_PERIOD);
   localparam logic [3:0] INIT_LEN_W   = 4'(INIT_LENGTH);
   localparam logic [3:0] MAX_LEN_W    = 4'(MAX_LENGTH);
   localparam logic [7:0] SCATTER_LAST = 8'(SCATTER_FRAMES - 1);
   localparam logic [7:0] RETREAT_LAST = 8'(RETREAT_FRAMES - 1);

   behaviour_t state, state_next;
   logic [3:0] length, length_next;
   logic       win_next;
   logic [5:0] tick_cnt;
   logic [5:0] period;
   logic       tick_wrap;
   logic [7:0] mode_cnt;
   logic [7:0] lfsr;
   logic [7:0] sel_target;

`ifdef DRAGON_SPEEDUP_EN
   always_comb begin
      if ({2'b00, length} + 6'd2 >= PERIOD_W)
         period = 6'd2;
      else
         period = PERIOD_W - {2'b00, length};
   end
`else
   assign period = PERIOD_W;
`endif

   // >= rather than == so a period that shrinks mid-count wraps immediately.
   assign tick_wrap = (tick_cnt >= period - 6'd1);

   dragon_target_select u_target_select (
      .state  (state),
      .head   (dragon_head_location),
      .player (player_location),
      .sheep  (sheep_location),
      .lfsr   (lfsr),
      .target (sel_target)
   );

   // Event priority: dragon_hit > sheep_eaten > player_hit > arrival/timeout.
   always_comb begin
      state_next  = state;
      length_next = length;
      win_next    = 1'b0;
      if (state != ST_DEAD) begin
         if (dragon_hit && (state != ST_RETREAT)) begin
            length_next = length - 4'd1;
            state_next  = (length == 4'd1) ? ST_DEAD : ST_RETREAT;
         end else if (sheep_eaten) begin
            if (length < MAX_LEN_W)
               length_next = length + 4'd1;
            if (state == ST_CONTEST)
               state_next = ST_SCATTER;
         end else if (player_hit && (state == ST_CONTEST)) begin
            win_next   = 1'b1;
            state_next = ST_SCATTER;
         end else if ((state == ST_SCATTER) &&
                      ((dragon_head_location == target_tile) || (mode_cnt == SCATTER_LAST))) begin
            state_next = ST_CONTEST;
         end else if ((state == ST_RETREAT) &&
                      ((dragon_head_location == target_tile) || (mode_cnt == RETREAT_LAST))) begin
            state_next = ST_CONTEST;
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (rst) begin
         state      <= ST_SCATTER;
         length     <= INIT_LEN_W;
         dragon_win <= 1'b0;
      end else begin
         state      <= state_next;
         length     <= length_next;
         dragon_win <= win_next;
      end
   end

   // Handshake: move_req rises on a tick wrap with target_tile latched alongside,
   // holds until move_ack is sampled high, then drops; ack while idle is ignored.
   always_ff @(posedge frame_clk) begin
      if (rst) begin
         tick_cnt    <= 6'd0;
         mode_cnt    <= 8'd0;
         lfsr        <= LFSR_SEED;
         move_req    <= 1'b0;
         target_tile <= LFSR_SEED;
      end else begin
         tick_cnt <= tick_wrap ? 6'd0 : tick_cnt + 6'd1;
         mode_cnt <= (state_next != state) ? 8'd0 : mode_cnt + 8'd1;
         lfsr     <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         if (state_next == ST_DEAD) begin
            move_req <= 1'b0;
         end else if (move_req) begin
            if (move_ack)
               move_req <= 1'b0;
         end else if (tick_wrap) begin
            move_req    <= 1'b1;
            target_tile <= sel_target;
         end
      end
   end

   assign behaviour_state = state;
   assign body_length     = length;
   assign game_over       = (state == ST_DEAD);

endmodule

// File: tb/tb_dragon_behaviour_ctrl.sv
// Bench for dragon_behaviour_ctrl: directed scenarios plus randomized traffic
// against a frame-level reference model of the behaviour rules.
module tb_dragon_behaviour_ctrl;

   localparam int         MOVE_PERIOD    = 8;
   localparam int         SCATTER_FRAMES = 120;
   localparam int         RETREAT_FRAMES = 90;
   localparam int         INIT_LENGTH    = 3;
   localparam int         MAX_LENGTH     = 8;
   localparam logic [7:0] LFSR_SEED      = 8'hA5;

   localparam logic [1:0] S_CONTEST = 2'b00;
   localparam logic [1:0] S_RETREAT = 2'b01;
   localparam logic [1:0] S_SCATTER = 2'b10;
   localparam logic [1:0] S_DEAD    = 2'b11;

   logic       frame_clk = 1'b0;
   logic       rst;
   logic [7:0] player_location;
   logic [7:0] sheep_location;
   logic [7:0] dragon_head_location;
   logic       sheep_eaten;
   logic       player_hit;
   logic       dragon_hit;
   logic       move_ack;
   logic       move_req;
   logic [7:0] target_tile;
   logic [1:0] behaviour_state;
   logic [3:0] body_length;
   logic       dragon_win;
   logic       game_over;

   int vectors     = 0;
   int miscompares = 0;

   // reference model state
   logic [1:0] m_state;
   int         m_len;
   logic       m_req;
   logic [7:0] m_target;
   logic       m_win;
   int         m_tick;
   int         m_mode;
   logic [7:0] m_lfsr;

   always #5 frame_clk = ~frame_clk;

   dragon_behaviour_ctrl #(
      .MOVE_PERIOD(MOVE_PERIOD), .SCATTER_FRAMES(SCATTER_FRAMES), .RETREAT_FRAMES(RETREAT_FRAMES),
      .INIT_LENGTH(INIT_LENGTH), .MAX_LENGTH(MAX_LENGTH), .LFSR_SEED(LFSR_SEED)
   ) dut (
      .frame_clk(frame_clk), .rst(rst),
      .player_location(player_location), .sheep_location(sheep_location),
      .dragon_head_location(dragon_head_location),
      .sheep_eaten(sheep_eaten), .player_hit(player_hit), .dragon_hit(dragon_hit),
      .move_ack(move_ack), .move_req(move_req), .target_tile(target_tile),
      .behaviour_state(behaviour_state), .body_length(body_length),
      .dragon_win(dragon_win), .game_over(game_over)
   );

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int period_for(input int len);
      int p;
      p = MOVE_PERIOD;
`ifdef DRAGON_SPEEDUP_EN
      p = MOVE_PERIOD - len;
      if (p < 2) p = 2;
`endif
      return p;
   endfunction

   function automatic logic [7:0] ref_target(input logic [1:0] st, input logic [7:0] head,
                                             input logic [7:0] player, input logic [7:0] sheep,
                                             input logic [7:0] lfsr);
      int dp, ds;
      dp = iabs(int'(head[3:0]) - int'(player[3:0])) + iabs(int'(head[7:4]) - int'(player[7:4]));
      ds = iabs(int'(head[3:0]) - int'(sheep[3:0])) + iabs(int'(head[7:4]) - int'(sheep[7:4]));
      if (st == S_CONTEST) return (dp < ds) ? player : sheep;
      if (st == S_RETREAT) return {(player[7:4] < 4'd8) ? 4'hF : 4'h0, (player[3:0] < 4'd8) ? 4'hF : 4'h0};
      return lfsr;
   endfunction

   // One frame of the game rules, applied to the inputs present at this edge.
   task automatic model_update();
      logic [1:0] ns;
      int         nl;
      logic       nw;
      logic       nr;
      logic [7:0] nt;
      bit         wrap;
      if (rst) begin
         m_state = S_SCATTER; m_len = INIT_LENGTH; m_req = 1'b0; m_target = LFSR_SEED;
         m_win = 1'b0; m_tick = 0; m_mode = 0; m_lfsr = LFSR_SEED;
         return;
      end
      wrap = (m_tick >= period_for(m_len) - 1);
      ns = m_state; nl = m_len; nw = 1'b0; nr = m_req; nt = m_target;
      if (m_state != S_DEAD) begin
         if (dragon_hit && m_state != S_RETREAT) begin
            nl = m_len - 1;
            ns = (nl == 0) ? S_DEAD : S_RETREAT;
         end else if (sheep_eaten) begin
            nl = (m_len + 1 > MAX_LENGTH) ? MAX_LENGTH : m_len + 1;
            if (m_state == S_CONTEST) ns = S_SCATTER;
         end else if (player_hit && m_state == S_CONTEST) begin
            nw = 1'b1; ns = S_SCATTER;
         end else if (m_state == S_SCATTER &&
                      (dragon_head_location == m_target || m_mode == SCATTER_FRAMES - 1)) begin
            ns = S_CONTEST;
         end else if (m_state == S_RETREAT &&
                      (dragon_head_location == m_target || m_mode == RETREAT_FRAMES - 1)) begin
            ns = S_CONTEST;
         end
      end
      if (ns == S_DEAD) nr = 1'b0;
      else if (m_req) nr = !move_ack;
      else if (wrap) begin
         nr = 1'b1;
         nt = ref_target(m_state, dragon_head_location, player_location, sheep_location, m_lfsr);
      end
      m_tick   = wrap ? 0 : m_tick + 1;
      m_mode   = (ns != m_state) ? 0 : (m_mode + 1) % 256;
      m_lfsr   = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      m_state  = ns; m_len = nl; m_win = nw; m_req = nr; m_target = nt;
   endtask

   task automatic tick();
      model_update();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sheep_eaten = 1'b0; player_hit = 1'b0; dragon_hit = 1'b0; move_ack = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic goto_contest(input logic [7:0] head_after);
      dragon_head_location = m_target;
      tick();
      dragon_head_location = head_after;
   endtask

   task automatic test_reset();
      player_location = 8'h00; sheep_location = 8'h11; dragon_head_location = 8'h00;
      rst = 1'b1; sheep_eaten = 1'b0; player_hit = 1'b0; dragon_hit = 1'b0; move_ack = 1'b1;
      tick(); tick();
      rst = 1'b0;
      vectors++; if (behaviour_state !== S_SCATTER) begin miscompares++; $display("FAIL reset_state got=%0h exp=%0h", behaviour_state, S_SCATTER); end
      vectors++; if (body_length !== 4'd3) begin miscompares++; $display("FAIL reset_length got=%0d exp=3", body_length); end
      vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL reset_move_req got=%b exp=0", move_req); end
      vectors++; if (target_tile !== 8'hA5) begin miscompares++; $display("FAIL reset_target got=%0h exp=a5", target_tile); end
      vectors++; if (dragon_win !== 1'b0) begin miscompares++; $display("FAIL reset_win got=%b exp=0", dragon_win); end
      vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
   endtask

   task automatic test_tick_period();
      int   rise_q[$];
      logic prev;
      int   exp_per;
      exp_per = period_for(INIT_LENGTH);
      prev = 1'b0;
      move_ack = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         vectors++; if (move_req !== m_req) begin miscompares++; $display("FAIL tick_req cyc=%0d got=%b exp=%b", i, move_req, m_req); end
         if (move_req && !prev) rise_q.push_back(i);
         prev = move_req;
      end
      vectors++;
      if (rise_q.size() < 2) begin
         miscompares++; $display("FAIL tick_rises got=%0d exp>=2", rise_q.size());
      end else begin
         if (rise_q[0] !== exp_per) begin miscompares++; $display("FAIL tick_first got=%0d exp=%0d", rise_q[0], exp_per); end
         for (int k = 1; k < rise_q.size(); k++) begin
            vectors++;
            if (rise_q[k] - rise_q[k-1] !== exp_per) begin miscompares++; $display("FAIL tick_interval got=%0d exp=%0d", rise_q[k] - rise_q[k-1], exp_per); end
         end
      end
   endtask

   task automatic wait_req(input logic level, input string name);
      for (int i = 0; i < 40 && move_req !== level; i++) tick();
      vectors++;
      if (move_req !== level) begin miscompares++; $display("FAIL %s_timeout got=%b exp=%b", name, move_req, level); end
   endtask

   task automatic test_contest_target();
      do_reset();
      move_ack = 1'b1; player_location = 8'h47; sheep_location = 8'h41;
      goto_contest(8'h44);
      vectors++; if (behaviour_state !== S_CONTEST) begin miscompares++; $display("FAIL contest_entry got=%0h exp=0", behaviour_state); end
      wait_req(1'b1, "contest_req1");
      vectors++; if (target_tile !== 8'h41) begin miscompares++; $display("FAIL contest_tie got=%0h exp=41", target_tile); end
      player_location = 8'h46;
      wait_req(1'b0, "contest_ack");
      wait_req(1'b1, "contest_req2");
      vectors++; if (target_tile !== 8'h46) begin miscompares++; $display("FAIL contest_player got=%0h exp=46", target_tile); end
   endtask

   task automatic test_retreat_hold();
      do_reset();
      move_ack = 1'b1; player_location = 8'h3C; sheep_location = 8'h41;
      goto_contest(8'h44);
      dragon_hit = 1'b1; tick(); dragon_hit = 1'b0;
      vectors++; if (behaviour_state !== S_RETREAT) begin miscompares++; $display("FAIL retreat_entry got=%0h exp=1", behaviour_state); end
      vectors++; if (body_length !== 4'd2) begin miscompares++; $display("FAIL retreat_length got=%0d exp=2", body_length); end
      wait_req(1'b0, "retreat_idle");
      move_ack = 1'b0;
      wait_req(1'b1, "retreat_req");
      vectors++; if (target_tile !== 8'hF0) begin miscompares++; $display("FAIL retreat_corner got=%0h exp=f0", target_tile); end
      for (int i = 0; i < 20; i++) begin
         tick();
         vectors++; if (move_req !== 1'b1) begin miscompares++; $display("FAIL retreat_hold_req cyc=%0d got=%b exp=1", i, move_req); end
         vectors++; if (target_tile !== 8'hF0) begin miscompares++; $display("FAIL retreat_hold_target cyc=%0d got=%0h exp=f0", i, target_tile); end
      end
   endtask

   task automatic test_dead();
      do_reset();
      move_ack = 1'b1; player_location = 8'h3C; sheep_location = 8'h41;
      goto_contest(8'h44);
      for (int i = 0; i < 2; i++) begin
         dragon_hit = 1'b1; tick(); dragon_hit = 1'b0;
         goto_contest(8'h44);
      end
      vectors++; if (behaviour_state !== S_CONTEST || body_length !== 4'd1) begin miscompares++; $display("FAIL dead_setup got=%0h/%0d exp=0/1", behaviour_state, body_length); end
      move_ack = 1'b0;
      wait_req(1'b1, "dead_pending");
      dragon_hit = 1'b1; sheep_eaten = 1'b1; tick(); dragon_hit = 1'b0; sheep_eaten = 1'b0;
      vectors++; if (body_length !== 4'd0) begin miscompares++; $display("FAIL dead_length got=%0d exp=0", body_length); end
      vectors++; if (behaviour_state !== S_DEAD) begin miscompares++; $display("FAIL dead_state got=%0h exp=3", behaviour_state); end
      vectors++; if (game_over !== 1'b1) begin miscompares++; $display("FAIL dead_game_over got=%b exp=1", game_over); end
      vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL dead_req got=%b exp=0", move_req); end
      for (int i = 0; i < 12; i++) begin
         tick();
         vectors++; if (move_req !== 1'b0 || behaviour_state !== S_DEAD) begin miscompares++; $display("FAIL dead_terminal cyc=%0d got=%b/%0h exp=0/3", i, move_req, behaviour_state); end
      end
   endtask

   task automatic test_length_saturation();
      int start;
      int exp_per;
      do_reset();
      dragon_head_location = 8'h00; move_ack = 1'b1;
      for (int i = 0; i < 10; i++) begin
         sheep_eaten = 1'b1; tick(); sheep_eaten = 1'b0; tick();
      end
      vectors++; if (body_length !== 4'd8) begin miscompares++; $display("FAIL sat_length got=%0d exp=8", body_length); end
      exp_per = period_for(MAX_LENGTH);
      wait_req(1'b0, "sat_idle");
      wait_req(1'b1, "sat_rise1");
      start = 0;
      for (int i = 1; i <= 20 && start == 0; i++) begin
         tick();
         if (move_req && !m_req) start = -1;
         if (move_req === 1'b0) begin
            for (int j = i + 1; j <= 20 && start == 0; j++) begin
               tick();
               if (move_req === 1'b1) start = j;
            end
         end
      end
      vectors++; if (start !== exp_per) begin miscompares++; $display("FAIL sat_period got=%0d exp=%0d", start, exp_per); end
   endtask

   task automatic test_reset_mid_request();
      do_reset();
      move_ack = 1'b1; player_location = 8'h3C; sheep_location = 8'h41;
      goto_contest(8'h44);
      dragon_hit = 1'b1; tick(); dragon_hit = 1'b0;
      move_ack = 1'b0;
      wait_req(1'b1, "midrst_req");
      vectors++; if (behaviour_state !== S_RETREAT) begin miscompares++; $display("FAIL midrst_state got=%0h exp=1", behaviour_state); end
      rst = 1'b1; move_ack = 1'b1; tick(); rst = 1'b0;
      vectors++; if (behaviour_state !== S_SCATTER) begin miscompares++; $display("FAIL midrst_out_state got=%0h exp=2", behaviour_state); end
      vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req got=%b exp=0", move_req); end
      vectors++; if (target_tile !== LFSR_SEED) begin miscompares++; $display("FAIL midrst_target got=%0h exp=a5", target_tile); end
      vectors++; if (body_length !== 4'd3) begin miscompares++; $display("FAIL midrst_length got=%0d exp=3", body_length); end
      vectors++; if (dragon_win !== 1'b0 || game_over !== 1'b0) begin miscompares++; $display("FAIL midrst_flags got=%b%b exp=00", dragon_win, game_over); end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++; if (move_req !== 1'b0) begin miscompares++; $display("FAIL midrst_late_ack cyc=%0d got=%b exp=0", i, move_req); end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rst                  = ($urandom_range(0, 199) == 0);
         player_location      = 8'($urandom_range(0, 255));
         sheep_location       = 8'($urandom_range(0, 255));
         dragon_head_location = ($urandom_range(0, 3) == 0) ? m_target : 8'($urandom_range(0, 255));
         sheep_eaten          = ($urandom_range(0, 11) == 0);
         player_hit           = ($urandom_range(0, 11) == 0);
         dragon_hit           = ($urandom_range(0, 11) == 0);
         move_ack             = 1'($urandom_range(0, 1));
         tick();
         vectors++; if (behaviour_state !== m_state) begin miscompares++; $display("FAIL rand_state cyc=%0d got=%0h exp=%0h", i, behaviour_state, m_state); end
         vectors++; if (body_length !== 4'(m_len)) begin miscompares++; $display("FAIL rand_length cyc=%0d got=%0d exp=%0d", i, body_length, m_len); end
         vectors++; if (move_req !== m_req) begin miscompares++; $display("FAIL rand_req cyc=%0d got=%b exp=%b", i, move_req, m_req); end
         vectors++; if (target_tile !== m_target) begin miscompares++; $display("FAIL rand_target cyc=%0d got=%0h exp=%0h", i, target_tile, m_target); end
         vectors++; if (dragon_win !== m_win) begin miscompares++; $display("FAIL rand_win cyc=%0d got=%b exp=%b", i, dragon_win, m_win); end
         vectors++; if (game_over !== (m_state == S_DEAD)) begin miscompares++; $display("FAIL rand_game_over cyc=%0d got=%b exp=%b", i, game_over, m_state == S_DEAD); end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_tick_period();
      test_contest_target();
      test_retreat_hold();
      test_dead();
      test_length_saturation();
      test_reset_mid_request();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
